// File: rtl/dbg_scan_pkg.sv
// ============================================================================
// dbg_scan_pkg: chain geometry helpers and scan FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package dbg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_OVER  = 2'd3
  } scan_state_t;

  function automatic int chain_len(input int nch, input int w, input int tmr_w);
    return nch * (w + 1) + tmr_w + 1;
  endfunction

  // Per channel the chain holds {ovr, data[W-1:0]}, channels packed from bit 0 up.
  function automatic int ch_data_lsb(input int c, input int w);
    return c * (w + 1);
  endfunction

  function automatic int ch_ovr_bit(input int c, input int w);
    return c * (w + 1) + w;
  endfunction

  function automatic int tmr_lsb(input int nch, input int w);
    return nch * (w + 1);
  endfunction

  function automatic int tmr_en_bit(input int nch, input int w, input int tmr_w);
    return nch * (w + 1) + tmr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_ovr_timer.sv
// ============================================================================
// dbg_ovr_timer: auto-release down-counter for the debug override register
// Rev 1.0
// ============================================================================
`default_nettype none

module dbg_ovr_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_en,
  input  logic [TMR_W-1:0] load_val,
  output logic             running,
  output logic             expire_now,
  output logic             expired,
  output logic [TMR_W-1:0] count
);

  logic start;

  assign start = load_en && (load_val != '0);
  // A load in the same cycle as the final decrement suppresses the expiry.
  assign expire_now = running && (count == TMR_W'(1)) && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= expire_now;
      if (load) begin
        running <= start;
        count   <= start ? load_val : '0;
      end else if (running) begin
        count <= count - TMR_W'(1);
        if (count == TMR_W'(1)) running <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbg_override_scan_n.sv
// ============================================================================
// dbg_override_scan_n: NCH-channel scan-loaded debug override with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module dbg_override_scan_n
  import dbg_scan_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int W     = 16,
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             capture,
  input  logic             update,
  input  logic [NCH*W-1:0] ch_in,
  output logic [NCH*W-1:0] ch_out,
  output logic [NCH-1:0]   ovr_active,
  output logic             update_err,
  output logic             timeout_expired
);

  localparam int CHAIN_LEN  = chain_len(NCH, W, TMR_W);
  localparam int CNT_W      = $clog2(CHAIN_LEN + 2);
  localparam int TMR_LSB    = tmr_lsb(NCH, W);
  localparam int TMR_EN_BIT = tmr_en_bit(NCH, W, TMR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] chain_cap;
  logic [NCH*W-1:0]     chain_data;
  logic [NCH-1:0]       chain_ovr;
  logic [NCH*W-1:0]     shadow;
  logic [NCH-1:0]       ovr;
  logic [CNT_W-1:0]     cnt;
  scan_state_t          state;
  scan_state_t          state_nxt;

  logic do_update;
  logic do_shift;
  logic accept;
  logic reject;

  logic             tmr_running;
  logic             tmr_expire_now;
  logic [TMR_W-1:0] tmr_count;

  assign do_update = update && !capture;
  assign do_shift  = scan_en && !capture && !update;
  assign accept    = do_update && (state == ST_FULL);
  assign reject    = do_update && (state != ST_FULL);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign chain_cap[ch_data_lsb(c, W) +: W] = ch_in[c*W +: W];
    assign chain_cap[ch_ovr_bit(c, W)]       = ovr[c];
    assign chain_data[c*W +: W]              = chain[ch_data_lsb(c, W) +: W];
    assign chain_ovr[c]                      = chain[ch_ovr_bit(c, W)];
    assign ch_out[c*W +: W] = ovr[c] ? shadow[c*W +: W] : ch_in[c*W +: W];
  end

  assign chain_cap[TMR_LSB +: TMR_W] = tmr_count;
  assign chain_cap[TMR_EN_BIT]       = tmr_running;

  assign scan_out   = chain[0];
  assign ovr_active = ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain      <= '0;
      cnt        <= '0;
      update_err <= 1'b0;
    end else if (capture) begin
      chain      <= chain_cap;
      cnt        <= '0;
      update_err <= 1'b0;
    end else if (do_update) begin
      cnt <= '0;
      if (reject) update_err <= 1'b1;
    end else if (do_shift) begin
      chain <= {scan_in, chain[CHAIN_LEN-1:1]};
      if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
    end
  end

  // Expiry only drops the override bits; shadow data survives for a later re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      ovr    <= '0;
    end else if (accept) begin
      shadow <= chain_data;
      ovr    <= chain_ovr;
    end else if (tmr_expire_now) begin
      ovr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (capture || update) begin
      state_nxt = ST_IDLE;
    end else if (scan_en) begin
      case (state)
        ST_IDLE, ST_SHIFT: state_nxt = ((cnt + CNT_W'(1)) == CNT_FULL) ? ST_FULL : ST_SHIFT;
        ST_FULL:           state_nxt = ST_OVER;
        ST_OVER:           state_nxt = ST_OVER;
        default:           state_nxt = ST_IDLE;
      endcase
    end
  end

  dbg_ovr_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_en    (chain[TMR_EN_BIT]),
    .load_val   (chain[TMR_LSB +: TMR_W]),
    .running    (tmr_running),
    .expire_now (tmr_expire_now),
    .expired    (timeout_expired),
    .count      (tmr_count)
  );

endmodule

`default_nettype wire
